// File: rtl/hilo_muldiv_unit.sv
// HI/LO register owner for the EX stage: single-cycle MULT/MULTU, MTHI/MTLO,
// MFHI/MFLO, and a radix-2 restoring divider that stalls the pipeline while busy.
module hilo_muldiv_unit #(
  parameter int WIDTH     = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid,
  input  logic [7:0]       alucontrol,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             stall_in,
  input  logic             flush,
  output logic             stall_req,
  output logic [WIDTH-1:0] mf_result,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(DIV_ITERS) + 1;

  logic [1:0]         state_r, state_nxt_s;
  logic [CW-1:0]      count_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic [WIDTH-1:0]   quo_r, rem_r, dvs_r;
  logic               neg_q_r, neg_r_r;

  logic               commit_s, is_div_s, is_signed_s, start_s, b_zero_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s, q_fix_s, r_fix_s;
  logic [WIDTH:0]     partial_s, diff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic               done_wr_s;

  assign commit_s    = valid & ~stall_in & ~flush;
  assign is_div_s    = (alucontrol == EXE_DIV_OP) | (alucontrol == EXE_DIVU_OP);
  assign is_signed_s = (alucontrol == EXE_DIV_OP);
  assign start_s     = (state_r == S_IDLE) & valid & ~flush & is_div_s;
  assign b_zero_s    = (src_b == {WIDTH{1'b0}});
  assign done_wr_s   = (state_r == S_DONE) & ~flush & ~stall_in;

  // Operand magnitudes for signed division; unsigned ops pass through.
  assign abs_a_s = (is_signed_s & src_a[WIDTH-1]) ? (~src_a + WIDTH'(1)) : src_a;
  assign abs_b_s = (is_signed_s & src_b[WIDTH-1]) ? (~src_b + WIDTH'(1)) : src_b;

  // One restoring step: shift next dividend bit into the remainder, trial-subtract.
  assign partial_s = {rem_r, quo_r[WIDTH-1]};
  assign diff_s    = partial_s - {1'b0, dvs_r};

  assign q_fix_s = neg_q_r ? (~quo_r + WIDTH'(1)) : quo_r;
  assign r_fix_s = neg_r_r ? (~rem_r + WIDTH'(1)) : rem_r;

  // Full-width product, sign- or zero-extended operands.
  always_comb begin
    prod_s = {(2*WIDTH){1'b0}};
    if (alucontrol == EXE_MULT_OP) begin
      prod_s = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
    end else begin
      prod_s = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
    end
  end

  // Divider next-state; flush always returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_s) begin
          state_nxt_s = b_zero_s ? S_DONE : S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_nxt_s = S_IDLE;
        end else if (count_r == CW'(DIV_ITERS - 1)) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE: begin
        if (flush | ~stall_in) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Busy request: asserted from the start cycle through the last iteration.
  always_comb begin
    stall_req = 1'b0;
    case (state_r)
      S_IDLE:  stall_req = start_s;
      S_RUN:   stall_req = 1'b1;
      S_DONE:  stall_req = 1'b0;
      default: stall_req = 1'b0;
    endcase
  end

  // Move-from result straight off the architectural registers.
  always_comb begin
    mf_result = {WIDTH{1'b0}};
    if (alucontrol == EXE_MFHI_OP) begin
      mf_result = hi_r;
    end else if (alucontrol == EXE_MFLO_OP) begin
      mf_result = lo_r;
    end else begin
      mf_result = {WIDTH{1'b0}};
    end
  end

  // Divider state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Divider datapath: operand latch at start, one shift/subtract per RUN cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r <= {CW{1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
      dvs_r   <= {WIDTH{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (start_s) begin
      count_r <= {CW{1'b0}};
      dvs_r   <= abs_b_s;
      if (b_zero_s) begin
        // Divide-by-zero reports raw all-ones quotient and the untouched dividend.
        quo_r   <= {WIDTH{1'b1}};
        rem_r   <= src_a;
        neg_q_r <= 1'b0;
        neg_r_r <= 1'b0;
      end else begin
        quo_r   <= abs_a_s;
        rem_r   <= {WIDTH{1'b0}};
        neg_q_r <= is_signed_s & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        neg_r_r <= is_signed_s & src_a[WIDTH-1];
      end
    end else if (state_r == S_RUN) begin
      count_r <= count_r + CW'(1);
      if (!diff_s[WIDTH]) begin
        rem_r <= diff_s[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_r <= partial_s[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      count_r <= count_r;
    end
  end

  // Architectural HI/LO: divider result on DONE exit, else committed single-cycle ops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (done_wr_s) begin
      hi_r <= r_fix_s;
      lo_r <= q_fix_s;
    end else if (commit_s) begin
      case (alucontrol)
        EXE_MULT_OP, EXE_MULTU_OP: begin
          hi_r <= prod_s[2*WIDTH-1:WIDTH];
          lo_r <= prod_s[WIDTH-1:0];
        end
        EXE_MTHI_OP: hi_r <= src_a;
        EXE_MTLO_OP: lo_r <= src_a;
        default: begin
          hi_r <= hi_r;
          lo_r <= lo_r;
        end
      endcase
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  assign hi_o = hi_r;
  assign lo_o = lo_r;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed scenarios plus randomized
// ops checked against an arithmetic reference model of HI/LO.
module tb_hilo_muldiv_unit;

  localparam logic [7:0] NOP   = 8'h00;
  localparam logic [7:0] MFHI  = 8'b0001_0000;
  localparam logic [7:0] MTHI  = 8'b0001_0001;
  localparam logic [7:0] MFLO  = 8'b0001_0010;
  localparam logic [7:0] MTLO  = 8'b0001_0011;
  localparam logic [7:0] MULT  = 8'b0001_1000;
  localparam logic [7:0] MULTU = 8'b0001_1001;
  localparam logic [7:0] DIV   = 8'b0001_1010;
  localparam logic [7:0] DIVU  = 8'b0001_1011;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid;
  logic [7:0]  alucontrol;
  logic [31:0] src_a, src_b;
  logic        stall_in, flush;
  logic        stall_req;
  logic [31:0] mf_result, hi_o, lo_o;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] m_hi = 32'h0, m_lo = 32'h0;

  hilo_muldiv_unit #(.WIDTH(32), .DIV_ITERS(32)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .alucontrol(alucontrol),
    .src_a(src_a), .src_b(src_b), .stall_in(stall_in), .flush(flush),
    .stall_req(stall_req), .mf_result(mf_result), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference division from the architectural rules, not the iteration.
  task automatic div_model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (op == DIVU) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'h0;
    end else begin
      sa = $signed(a); sb = $signed(b);
      q = 32'(sa / sb); r = 32'(sa % sb);
    end
  endtask

  task automatic check_hilo(input string name);
    vectors++;
    if (hi_o !== m_hi || lo_o !== m_lo) begin
      errors++;
      $display("FAIL %s: hi=%h lo=%h expected hi=%h lo=%h", name, hi_o, lo_o, m_hi, m_lo);
    end
  endtask

  task automatic idle_inputs;
    valid = 1'b0; alucontrol = NOP; stall_in = 1'b0; flush = 1'b0;
  endtask

  task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    valid = 1'b1; alucontrol = op; src_a = a; src_b = b;
    #1;
    vectors++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL single_op_nostall: stall_req=%b expected 0 (op %h)", stall_req, op);
    end
    tick;
    idle_inputs();
    case (op)
      MULT:  begin p = 64'(longint'($signed(a)) * longint'($signed(b))); m_hi = p[63:32]; m_lo = p[31:0]; end
      MULTU: begin p = {32'h0, a} * {32'h0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      MTHI:  m_hi = a;
      MTLO:  m_lo = a;
      default: ;
    endcase
    #1;
    check_hilo("single_op");
  endtask

  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
    logic [31:0] q, r;
    int n, exp_n;
    div_model(op, a, b, q, r);
    exp_n = (b == 32'h0) ? 1 : 33;
    valid = 1'b1; alucontrol = op; src_a = a; src_b = b; stall_in = 1'b0; flush = 1'b0;
    #1;
    n = 0;
    while (stall_req === 1'b1 && n < 100) begin
      n++;
      tick;
    end
    vectors++;
    if (n != exp_n) begin
      errors++;
      $display("FAIL div_stall_cycles: %0d cycles expected %0d (a=%h b=%h)", n, exp_n, a, b);
    end
    stall_in = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick;
      check_hilo("div_hold_in_done");
      vectors++;
      if (stall_req !== 1'b0) begin
        errors++;
        $display("FAIL div_done_stall: stall_req=%b expected 0", stall_req);
      end
    end
    stall_in = 1'b0;
    tick;
    idle_inputs();
    m_lo = q; m_hi = r;
    #1;
    check_hilo("div_result");
  endtask

  task automatic check_mf(input logic [7:0] op, input logic [31:0] exp, input string name);
    alucontrol = op;
    #1;
    vectors++;
    if (mf_result !== exp) begin
      errors++;
      $display("FAIL %s: mf_result=%h expected %h", name, mf_result, exp);
    end
    alucontrol = NOP;
  endtask

  task automatic test_reset;
    #1;
    check_hilo("reset_hilo");
    vectors++;
    if (stall_req !== 1'b0 || mf_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: stall_req=%b mf_result=%h expected 0 0", stall_req, mf_result);
    end
  endtask

  task automatic test_directed;
    run_div(DIV, 32'd7, 32'hFFFF_FFFE, 0);
    run_div(DIVU, 32'hFFFF_FFFF, 32'd16, 0);
    check_mf(MFLO, 32'h0FFF_FFFF, "mflo_after_divu");
    do_op(MULT, 32'hFFFF_FFFD, 32'd5);
    do_op(MULTU, 32'hFFFF_FFFF, 32'd2);
    run_div(DIV, 32'h1234, 32'h0, 0);
    do_op(MTHI, 32'h5555, 32'h0);
    do_op(MTLO, 32'h6666, 32'h0);
    run_div(DIV, 32'h1234, 32'h0, 3);
    run_div(DIVU, 32'd1000, 32'd7, 2);
    check_mf(MFHI, m_hi, "mfhi_after_div");
    check_mf(NOP, 32'h0, "mf_other_op");
  endtask

  task automatic test_flush;
    logic [31:0] lo_before;
    do_op(MTHI, 32'hAAAA, 32'h0);
    lo_before = m_lo;
    valid = 1'b1; alucontrol = DIV; src_a = 32'd12345; src_b = 32'd17;
    #1;
    tick;
    for (int i = 0; i < 9; i++) tick;
    vectors++;
    if (stall_req !== 1'b1) begin
      errors++;
      $display("FAIL flush_run_busy: stall_req=%b expected 1", stall_req);
    end
    flush = 1'b1;
    tick;
    idle_inputs();
    #1;
    vectors++;
    if (stall_req !== 1'b0 || hi_o !== 32'hAAAA || lo_o !== lo_before) begin
      errors++;
      $display("FAIL flush_abort: stall_req=%b hi=%h lo=%h expected 0 0000aaaa %h",
               stall_req, hi_o, lo_o, lo_before);
    end
    run_div(DIV, 32'hFFFF_FF9C, 32'd7, 0);
  endtask

  task automatic test_reset_mid;
    valid = 1'b1; alucontrol = DIV; src_a = 32'd999; src_b = 32'd3;
    #1;
    for (int i = 0; i < 5; i++) tick;
    idle_inputs();
    resetn = 1'b0;
    #1;
    m_hi = 32'h0; m_lo = 32'h0;
    check_hilo("reset_mid_hilo");
    vectors++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stall: stall_req=%b expected 0", stall_req);
    end
    #2 resetn = 1'b1;
    tick;
    run_div(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_random;
    logic [7:0] ops [6];
    logic [7:0] op;
    logic [31:0] a, b;
    ops = '{MULT, MULTU, DIV, DIVU, MTHI, MTLO};
    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 5)];
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'h0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      if (op == DIV || op == DIVU) run_div(op, a, b, $urandom_range(0, 2));
      else do_op(op, a, b);
      check_mf(MFHI, m_hi, "rand_mfhi");
      check_mf(MFLO, m_lo, "rand_mflo");
    end
  endtask

  initial begin
    resetn = 1'b0;
    src_a = 32'h0; src_b = 32'h0;
    idle_inputs();
    repeat (2) @(posedge clk);
    test_reset();
    #2 resetn = 1'b1;
    tick;
    test_directed();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
